// File: rtl/vrf_write_pkg.sv
// Shared types for the VRF write sink: request record, field widths, bank address helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vrf_write_pkg;

  localparam int VRF_DATA_W = 32;
  localparam int VRF_MASK_W = VRF_DATA_W / 8;
  localparam int VRF_VD_W   = 5;
  localparam int VRF_IDX_W  = 3;
  localparam int VRF_ADDR_W = VRF_VD_W + 1;

  // One buffered write request as it arrives from the lane.
  typedef struct packed {
    logic [VRF_VD_W-1:0]   vd;
    logic                  offset;
    logic [VRF_MASK_W-1:0] mask;
    logic [VRF_DATA_W-1:0] data;
    logic                  last;
    logic [VRF_IDX_W-1:0]  instructionIndex;
  } vrf_write_req_t;

  // Bank row address: register index in the upper bits, register half in bit 0.
  function automatic logic [VRF_ADDR_W-1:0] vrf_addr(input logic [VRF_VD_W-1:0] vd,
                                                     input logic offset);
    return {vd, offset};
  endfunction

endpackage

// File: rtl/vrf_write_buffer.sv
// Circular request buffer with every slot exposed for busy tracking and bypass lookup.
// Latency: an entry pushed on edge N appears at head/slots after edge N (registered, no fallthrough).
// Backpressure: full when every slot is valid; the caller must not push while full.
module vrf_write_buffer
  import vrf_write_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  vrf_write_req_t             push_dat,
  input  logic                       pop,
  output logic                       full,
  output logic                       head_vld,
  output vrf_write_req_t             head_dat,
  output logic [$clog2(DEPTH)-1:0]   head_ptr,
  output logic [DEPTH-1:0]           ent_vld,
  output vrf_write_req_t             ent_dat [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  vrf_write_req_t   mem_q [DEPTH];
  vrf_write_req_t   mem_d [DEPTH];

  // Pointer, valid-bit and payload next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    mem_d    = mem_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
  end

  // Control state; reset empties the buffer regardless of what was in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage; contents are always qualified by vld_q so they need no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign full     = &vld_q;
  assign head_vld = vld_q[rd_ptr_q];
  assign head_dat = mem_q[rd_ptr_q];
  assign head_ptr = rd_ptr_q;
  assign ent_vld  = vld_q;
  assign ent_dat  = mem_q;

endmodule

// File: rtl/vrf_write_sink.sv
// VRF write sink: buffers lane writes, drives one bank write port, reports done/busy/commit count (opt. VRF_WRITE_BYPASS_EN).
// Latency: bank write earliest 1 cycle after accept; instWriteDone pulses 1 cycle after the last write retires.
// Backpressure: ready=0 while buffer full (registered state only); bank stalls hold the head write stable.
module vrf_write_sink
  import vrf_write_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int DATA_WIDTH     = VRF_DATA_W,
  parameter int MASK_WIDTH     = DATA_WIDTH / 8,
  parameter int VD_WIDTH       = VRF_VD_W,
  parameter int INST_IDX_WIDTH = VRF_IDX_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         vrfWriteRequest_valid,
  output logic                         vrfWriteRequest_ready,
  input  logic [VD_WIDTH-1:0]          vrfWriteRequest_bits_vd,
  input  logic                         vrfWriteRequest_bits_offset,
  input  logic [MASK_WIDTH-1:0]        vrfWriteRequest_bits_mask,
  input  logic [DATA_WIDTH-1:0]        vrfWriteRequest_bits_data,
  input  logic                         vrfWriteRequest_bits_last,
  input  logic [INST_IDX_WIDTH-1:0]    vrfWriteRequest_bits_instructionIndex,
  output logic                         bankWrite_valid,
  input  logic                         bankWrite_ready,
  output logic [VD_WIDTH:0]            bankWrite_addr,
  output logic [MASK_WIDTH-1:0]        bankWrite_mask,
  output logic [DATA_WIDTH-1:0]        bankWrite_data,
  output logic [2**INST_IDX_WIDTH-1:0] instWriteDone,
  output logic [2**INST_IDX_WIDTH-1:0] instBusy,
  input  logic [VD_WIDTH:0]            readQuery_addr,
  output logic                         readQuery_hit,
  output logic [MASK_WIDTH-1:0]        readQuery_mask,
  output logic [DATA_WIDTH-1:0]        readQuery_data,
  output logic [15:0]                  commitCount
);

  // Width parameters exist for port documentation; the request record is sized by vrf_write_pkg
  // and the two must agree.
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int NUM_INST = 2 ** INST_IDX_WIDTH;

  vrf_write_req_t   req_dat;
  vrf_write_req_t   head_dat;
  vrf_write_req_t   ent_dat [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0] head_ptr;
  logic             full;
  logic             head_vld;
  logic             accept;
  logic             retire;

  logic [NUM_INST-1:0] done_q, done_d;
  logic [15:0]         commit_q, commit_d;

  assign req_dat = '{vd:               vrfWriteRequest_bits_vd,
                     offset:           vrfWriteRequest_bits_offset,
                     mask:             vrfWriteRequest_bits_mask,
                     data:             vrfWriteRequest_bits_data,
                     last:             vrfWriteRequest_bits_last,
                     instructionIndex: vrfWriteRequest_bits_instructionIndex};

  // Ready comes from buffer state only, so a retire in the full cycle does not open the door early.
  assign vrfWriteRequest_ready = ~full;
  assign accept                = vrfWriteRequest_valid & ~full;

  // Fully masked writes never touch the bank; they drain in one cycle but still count and complete.
  assign bankWrite_valid = head_vld & (|head_dat.mask);
  assign bankWrite_addr  = vrf_addr(head_dat.vd, head_dat.offset);
  assign bankWrite_mask  = head_dat.mask;
  assign bankWrite_data  = head_dat.data;
  assign retire          = head_vld & ((head_dat.mask == '0) | bankWrite_ready);

  vrf_write_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .push_dat (req_dat),
    .pop      (retire),
    .full     (full),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .head_ptr (head_ptr),
    .ent_vld  (ent_vld),
    .ent_dat  (ent_dat)
  );

  // Completion pulse and retire counter next state.
  always_comb begin
    done_d = '0;
    if (retire && head_dat.last) begin
      done_d[head_dat.instructionIndex] = 1'b1;
    end
    commit_d = commit_q + 16'(retire);
  end

  // Done pulse and counter registers; reset drops any pulse that was about to fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q   <= '0;
      commit_q <= '0;
    end else begin
      done_q   <= done_d;
      commit_q <= commit_d;
    end
  end

  assign instWriteDone = done_q;
  assign commitCount   = commit_q;

  // Busy bit per instruction slot owning at least one buffered entry.
  always_comb begin
    instBusy = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_vld[e]) begin
        instBusy[ent_dat[e].instructionIndex] = 1'b1;
      end
    end
  end

`ifdef VRF_WRITE_BYPASS_EN
  logic [PTR_W-1:0] slot;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    readQuery_hit  = 1'b0;
    readQuery_mask = '0;
    readQuery_data = '0;
    slot           = head_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_ptr + PTR_W'(k);
      if (ent_vld[slot] && (vrf_addr(ent_dat[slot].vd, ent_dat[slot].offset) == readQuery_addr)) begin
        readQuery_hit  = 1'b1;
        readQuery_mask = ent_dat[slot].mask;
        readQuery_data = ent_dat[slot].data;
      end
    end
  end
`else
  logic unused_bypass;

  // Lookup inputs and slot payloads are only consumed when the bypass is built.
  always_comb begin
    unused_bypass = ^{readQuery_addr, head_ptr};
    for (int k = 0; k < DEPTH; k++) begin
      unused_bypass = unused_bypass ^ (^ent_dat[k]);
    end
  end

  assign readQuery_hit  = 1'b0;
  assign readQuery_mask = '0;
  assign readQuery_data = '0;
`endif

endmodule

// File: tb/tb_vrf_write_sink.sv
module tb_vrf_write_sink;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_vld;
  logic        req_rdy;
  logic [4:0]  req_vd;
  logic        req_off;
  logic [3:0]  req_mask;
  logic [31:0] req_data;
  logic        req_last;
  logic [2:0]  req_idx;
  logic        bw_vld;
  logic        bw_rdy;
  logic [5:0]  bw_addr;
  logic [3:0]  bw_mask;
  logic [31:0] bw_data;
  logic [7:0]  done;
  logic [7:0]  busy;
  logic [5:0]  q_addr;
  logic        q_hit;
  logic [3:0]  q_mask;
  logic [31:0] q_data;
  logic [15:0] commit;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_commit = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [4:0]  vd;
    logic        off;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        last;
    logic [2:0]  idx;
    logic        exp_bw;
    logic [5:0]  exp_addr;
    logic [7:0]  exp_busy;
    logic [7:0]  exp_done;
  } vec_t;
  vec_t vecs[5];

  vrf_write_sink #(.DEPTH(2)) dut (
    .clock                                 (clock),
    .reset                                 (reset),
    .vrfWriteRequest_valid                 (req_vld),
    .vrfWriteRequest_ready                 (req_rdy),
    .vrfWriteRequest_bits_vd               (req_vd),
    .vrfWriteRequest_bits_offset           (req_off),
    .vrfWriteRequest_bits_mask             (req_mask),
    .vrfWriteRequest_bits_data             (req_data),
    .vrfWriteRequest_bits_last             (req_last),
    .vrfWriteRequest_bits_instructionIndex (req_idx),
    .bankWrite_valid                       (bw_vld),
    .bankWrite_ready                       (bw_rdy),
    .bankWrite_addr                        (bw_addr),
    .bankWrite_mask                        (bw_mask),
    .bankWrite_data                        (bw_data),
    .instWriteDone                         (done),
    .instBusy                              (busy),
    .readQuery_addr                        (q_addr),
    .readQuery_hit                         (q_hit),
    .readQuery_mask                        (q_mask),
    .readQuery_data                        (q_data),
    .commitCount                           (commit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic [4:0] vd, input logic off, input logic [3:0] mask,
                       input logic [31:0] data, input logic last, input logic [2:0] idx);
    req_vd = vd; req_off = off; req_mask = mask; req_data = data; req_last = last; req_idx = idx;
    req_vld = 1'b1;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Wait (bounded) until nothing is expected and the bank port is idle; returns at posedge+1.
  task automatic drain(input string nm);
    int n = 0;
    @(negedge clock);
    while ((sb.size() != 0 || bw_vld) && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_drained"}, (sb.size() == 0 && !bw_vld), 1);
    step();
  endtask

  // Scoreboard: pop and compare on each bank handshake, push on each accepted non-empty write.
  always @(negedge clock) begin
    if (!reset) begin
      if (bw_vld && bw_rdy) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_write", {bw_addr, bw_mask, bw_data}, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_addr", bw_addr, e.addr);
          chk("sb_mask", bw_mask, e.mask);
          chk("sb_data", bw_data, e.data);
        end
      end
      if (req_vld && req_rdy && req_mask != 4'h0)
        sb.push_back('{addr: {req_vd, req_off}, mask: req_mask, data: req_data});
    end
  end

  initial begin
    vecs[0] = '{5'd3,  1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 3'd2, 1'b1, 6'h07, 8'h04, 8'h04};
    vecs[1] = '{5'd5,  1'b0, 4'h3, 32'h12345678, 1'b0, 3'd1, 1'b1, 6'h0A, 8'h02, 8'h00};
    vecs[2] = '{5'd0,  1'b0, 4'h0, 32'h0000CAFE, 1'b1, 3'd5, 1'b0, 6'h00, 8'h20, 8'h20};
    vecs[3] = '{5'd31, 1'b1, 4'h8, 32'hA5A5A5A5, 1'b1, 3'd7, 1'b1, 6'h3F, 8'h80, 8'h80};
    vecs[4] = '{5'd16, 1'b0, 4'h1, 32'h00000001, 1'b0, 3'd0, 1'b1, 6'h20, 8'h01, 8'h00};

    reset = 1'b1; req_vld = 1'b0; bw_rdy = 1'b0; q_addr = 6'h00;
    req_vd = '0; req_off = 1'b0; req_mask = '0; req_data = '0; req_last = 1'b0; req_idx = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", req_rdy, 1);
    chk("rst_bw_valid", bw_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit", q_hit, 0);
    chk("rst_commit", commit, 0);
    step();

    // Table-driven single writes with the bank always granting.
    bw_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].vd, vecs[i].off, vecs[i].mask, vecs[i].data, vecs[i].last, vecs[i].idx);
      @(negedge clock);
      chk("vec_ready", req_rdy, 1);
      chk("vec_done_idle", done, 0);
      step();
      req_vld = 1'b0;
      @(negedge clock);
      chk("vec_busy", busy, vecs[i].exp_busy);
      chk("vec_bw_valid", bw_vld, vecs[i].exp_bw);
      if (vecs[i].exp_bw) chk("vec_addr", bw_addr, vecs[i].exp_addr);
      step();
      exp_commit++;
      @(negedge clock);
      chk("vec_done", done, vecs[i].exp_done);
      chk("vec_commit", commit, exp_commit);
      chk("vec_busy_clr", busy, 0);
      step();
    end

    // Stalled bank: third request held, full-cycle retire does not accept, order preserved.
    bw_rdy = 1'b0;
    drive(5'd2, 1'b0, 4'hF, 32'h0000A0A0, 1'b0, 3'd1);
    @(negedge clock); chk("stall_rdy_a", req_rdy, 1);
    step();
    drive(5'd2, 1'b1, 4'hF, 32'h0000B0B0, 1'b0, 3'd1);
    @(negedge clock); chk("stall_rdy_b", req_rdy, 1);
    step();
    drive(5'd4, 1'b0, 4'hF, 32'h0000C0C0, 1'b1, 3'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("stall_full_rdy", req_rdy, 0);
      chk("stall_bw_vld", bw_vld, 1);
      chk("stall_addr", bw_addr, 6'h04);
      chk("stall_data", bw_data, 32'h0000A0A0);
      step();
    end
    bw_rdy = 1'b1;
    @(negedge clock); chk("full_retire_rdy", req_rdy, 0);
    step();
    @(negedge clock); chk("after_full_rdy", req_rdy, 1);
    step();
    req_vld = 1'b0;
    drain("stall");
    exp_commit += 3;
    @(negedge clock); chk("stall_commit", commit, exp_commit);
    step();

    // Bypass lookup against two stalled writes to the same row.
    bw_rdy = 1'b0;
    q_addr = 6'h0A;
    drive(5'd5, 1'b0, 4'h3, 32'h00000011, 1'b0, 3'd0);
    @(negedge clock); chk("byp_empty_hit", q_hit, 0);
    step();
    drive(5'd5, 1'b0, 4'hC, 32'h00000022, 1'b0, 3'd0);
    @(negedge clock);
`ifdef VRF_WRITE_BYPASS_EN
    chk("byp_one_hit", q_hit, 1);
    chk("byp_one_data", q_data, 32'h11);
`else
    chk("byp_one_hit", q_hit, 0);
    chk("byp_one_data", q_data, 0);
`endif
    step();
    req_vld = 1'b0;
    @(negedge clock);
    chk("byp_bw_addr", bw_addr, 6'h0A);
`ifdef VRF_WRITE_BYPASS_EN
    chk("byp_two_hit", q_hit, 1);
    chk("byp_two_data", q_data, 32'h22);
    chk("byp_two_mask", q_mask, 4'hC);
`else
    chk("byp_two_hit", q_hit, 0);
    chk("byp_two_data", q_data, 0);
    chk("byp_two_mask", q_mask, 0);
`endif
    q_addr = 6'h0B;
    #1 chk("byp_miss", q_hit, 0);
    step();
    bw_rdy = 1'b1;
    drain("byp");
    exp_commit += 2;
    @(negedge clock); chk("byp_commit", commit, exp_commit);
    step();

    // Reset with two stalled last-writes: everything is discarded.
    bw_rdy = 1'b0;
    drive(5'd1, 1'b0, 4'hF, 32'h00000033, 1'b1, 3'd3);
    step();
    drive(5'd1, 1'b1, 4'hF, 32'h00000044, 1'b1, 3'd4);
    step();
    req_vld = 1'b0;
    @(negedge clock);
    chk("pre_rst_busy", busy, 8'h18);
    chk("pre_rst_bw_vld", bw_vld, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ready", req_rdy, 1);
    chk("mid_rst_bw_vld", bw_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_commit", commit, 0);
    sb.delete();
    exp_commit = 0;
    step();
    reset = 1'b0;
    bw_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("post_rst_done", done, 0);
      chk("post_rst_bw_vld", bw_vld, 0);
      chk("post_rst_commit", commit, 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x1 expected 0x0");
    $fatal(1, "timeout");
  end

endmodule
